// File: rtl/jk_pkg.sv
// jk_pkg: shared JK command encoding for JK-cell based blocks.
package jk_pkg;
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop driven by a 2-bit command, async active-high reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd,
  output logic       q,
  output logic       qn
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else q <= cmd == JK_HOLD  ? q :
              cmd == JK_RESET ? 1'b0 :
              cmd == JK_SET   ? 1'b1 : ~q;
  end
  assign qn = ~q;
endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down counter built from a row of JK cells.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   q,
  output logic               tc,
  output logic               wrap,
  output logic [2*WIDTH-1:0] cmd
);
  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("jk_mod_counter: WIDTH must be 2..8");
  end
  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_mod
    $error("jk_mod_counter: MODULUS must be 2..2**WIDTH");
  end
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] ld_val;
  logic             at_top;
  logic             at_zero;
  logic             ones;
  logic             zeros;
  assign ld_val  = din > MAXV ? MAXV : din;
  assign at_top  = q >= MAXV;
  assign at_zero = &qn;
  assign tc      = en & ~load & ((up & (q == MAXV)) | (~up & at_zero));
  // ones/zeros track whether all lower bits are 1/0, i.e. the ripple carry/borrow into bit i
  always_comb begin
    cmd   = '0;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cmd[2*i +: 2] = load ? (ld_val[i] ? JK_SET : JK_RESET) :
                      !en  ? JK_HOLD :
                      up   ? (at_top ? JK_RESET : ones ? JK_TOGGLE : JK_HOLD) :
                             (at_zero ? (MAXV[i] ? JK_SET : JK_RESET) : zeros ? JK_TOGGLE : JK_HOLD);
      ones  = ones & q[i];
      zeros = zeros & qn[i];
    end
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .cmd (cmd[2*g +: 2]),
      .q   (q[g]),
      .qn  (qn[g])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else wrap <= tc;
  end
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed stimulus against a behavioural modulo-counter model.
module tb_jk_mod_counter;
  localparam int W = 4;
  localparam int M = 10;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           up = 1'b1;
  logic           load = 1'b0;
  logic [W-1:0]   din = '0;
  logic [W-1:0]   q;
  logic           tc;
  logic           wrap;
  logic [2*W-1:0] cmd;
  int checks = 0;
  int failures = 0;
  int m_q = 0;
  bit m_wrap = 1'b0;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .din(din), .q(q), .tc(tc), .wrap(wrap), .cmd(cmd)
  );

  always #5 clk = ~clk;

  function automatic int next_of(int cur);
    if (load) return (int'(din) > M - 1) ? M - 1 : int'(din);
    if (!en) return cur;
    if (up) return (cur >= M - 1) ? 0 : cur + 1;
    return (cur == 0) ? M - 1 : cur - 1;
  endfunction

  function automatic bit tc_of(int cur);
    return en && !load && ((up && cur == M - 1) || (!up && cur == 0));
  endfunction

  // loads and wraps force every bit to its target; plain counting toggles exactly the bits that change
  function automatic logic [2*W-1:0] cmd_of(int cur);
    logic [2*W-1:0] c;
    int nx;
    c = '0;
    nx = next_of(cur);
    for (int i = 0; i < W; i++) begin
      if (load || (en && (tc_of(cur) || (up && cur >= M - 1))))
        c[2*i +: 2] = nx[i] ? 2'b10 : 2'b01;
      else if (en && (cur[i] != nx[i]))
        c[2*i +: 2] = 2'b11;
    end
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = 0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = tc_of(m_q);
      m_q = next_of(m_q);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_q", int'(q), m_q);
      chk("model_tc", int'(tc), int'(tc_of(m_q)));
      chk("model_wrap", int'(wrap), int'(m_wrap));
      chk("model_cmd", int'(cmd), int'(cmd_of(m_q)));
    end
  end

  task automatic set_in(input bit e, input bit u, input bit l, input int d);
    en = e;
    up = u;
    load = l;
    din = W'(d);
  endtask

  task automatic step(input bit e, input bit u, input bit l, input int d);
    set_in(e, u, l, d);
    @(posedge clk);
    #2;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("reset_q", int'(q), 0);
    chk("reset_wrap", int'(wrap), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) step(1, 1, 0, 0);
    chk("count_to_6", int'(q), 6);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst_q", int'(q), 1);

    step(0, 1, 1, 0);
    chk("load0", int'(q), 0);
    for (int k = 1; k <= 12; k++) begin
      set_in(1, 1, 0, 0);
      #1;
      if (k == 8) chk("cmd_7to8", int'(cmd), 8'hFF);
      if (k == 10) chk("tc_at_9", int'(tc), 1);
      if (k == 9) chk("tc_at_8", int'(tc), 0);
      step(1, 1, 0, 0);
      chk("up_q", int'(q), k % 10);
      if (k == 10) chk("wrap_up", int'(wrap), 1);
      if (k == 11) chk("wrap_gone", int'(wrap), 0);
    end

    step(0, 1, 1, 1);
    step(1, 0, 0, 0);
    chk("down_q0", int'(q), 0);
    set_in(1, 0, 0, 0);
    #1;
    chk("cmd_0to9", int'(cmd), 8'h96);
    chk("tc_at_0", int'(tc), 1);
    step(1, 0, 0, 0);
    chk("down_q9", int'(q), 9);
    chk("wrap_down", int'(wrap), 1);
    step(1, 0, 0, 0);
    chk("down_q8", int'(q), 8);

    set_in(1, 1, 1, 5);
    #1;
    chk("tc_load", int'(tc), 0);
    step(1, 1, 1, 5);
    chk("load5", int'(q), 5);
    step(1, 1, 1, 13);
    chk("load_clamp", int'(q), 9);
    chk("wrap_after_load", int'(wrap), 0);

    step(0, 1, 1, 3);
    for (int k = 0; k < 5; k++) begin
      set_in(0, k[0], 0, 15 - k);
      #1;
      chk("hold_cmd", int'(cmd), 0);
      chk("hold_tc", int'(tc), 0);
      step(0, k[0], 0, 15 - k);
      chk("hold_q", int'(q), 3);
      chk("hold_wrap", int'(wrap), 0);
    end

    step(0, 1, 1, 9);
    step(1, 0, 0, 0);
    chk("flip_q8", int'(q), 8);
    chk("flip_nowrap", int'(wrap), 0);
    step(1, 1, 0, 0);
    chk("flip_q9", int'(q), 9);
    step(1, 1, 0, 0);
    chk("flip_q0", int'(q), 0);
    chk("flip_wrap", int'(wrap), 1);
    step(0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
